// File: rtl/load_unit_if.sv
// Memory-controller load channel and store-buffer forwarding channel of the
// load unit. Member names carry the direction as seen from the load unit.
interface load_unit_if;
  logic        load_request_o;
  logic [31:0] load_address_o;
  logic        load_valid_i;
  logic [31:0] load_data_i;
  logic        buffer_empty_i;
  logic [29:0] foward_address_o;
  logic [31:0] foward_data_i;
  logic        foward_match_i;

  modport master (
    output load_request_o,
    output load_address_o,
    input  load_valid_i,
    input  load_data_i,
    input  buffer_empty_i,
    output foward_address_o,
    input  foward_data_i,
    input  foward_match_i
  );

  modport slave (
    input  load_request_o,
    input  load_address_o,
    output load_valid_i,
    output load_data_i,
    output buffer_empty_i,
    input  foward_address_o,
    output foward_data_i,
    output foward_match_i
  );
endinterface

// File: rtl/load_unit.sv
// Load path of the memory unit.
// Checks alignment and privilege, takes the word from the store buffer on an
// address hit or issues one read to the memory controller, extracts and
// extends the addressed byte/half/word and holds it until writeback accepts.
// Optional feature macro: LSU_STORE_FORWARD_EN (store-to-load forwarding).
// Without it loads wait for an empty store buffer and never bypass stores.
// Private region bounds: PRIVATE_REGION_START / PRIVATE_REGION_END.

`ifndef PRIVATE_REGION_START
`define PRIVATE_REGION_START 32'hF000_0000
`endif
`ifndef PRIVATE_REGION_END
`define PRIVATE_REGION_END 32'hF00F_FFFF
`endif

module load_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        privilege_i,
  input  logic        valid_operation_i,
  input  logic [31:0] load_address_i,
  input  logic [2:0]  operation_i,
  input  logic        wait_i,
  load_unit_if.master bus,
  output logic [31:0] loaded_data_o,
  output logic        data_valid_o,
  output logic        idle_o,
  output logic        illegal_access_o,
  output logic        misaligned_o
);

  localparam logic [2:0] OP_LDB  = 3'd0;
  localparam logic [2:0] OP_LDBU = 3'd1;
  localparam logic [2:0] OP_LDH  = 3'd2;
  localparam logic [2:0] OP_LDHU = 3'd3;
  localparam logic [2:0] OP_LDW  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_MEMORY = 2'd1,
    S_WAIT_ACCEPT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        drop_q, drop_d;
  logic [2:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] result_q, result_d;

  logic live_w;
  logic accept_w;
  logic misaligned_w;
  logic private_w;
  logic illegal_w;
  logic exception_w;
  logic fwd_hit_w;
  logic mem_go_w;
  logic hold_w;
  logic mem_ret_w;
  logic result_en_w;

  logic        req_w;
  logic [31:0] req_addr_w;
  logic [29:0] fwd_addr_w;

  // Pick the addressed lane of a word and sign/zero-extend it
  function automatic logic [31:0] extract_load(input logic [2:0]  op,
                                               input logic [1:0]  lo,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LDB:  extract_load = {{24{b[7]}}, b};
      OP_LDBU: extract_load = {24'd0, b};
      OP_LDH:  extract_load = {{16{h[15]}}, h};
      OP_LDHU: extract_load = {16'd0, h};
      default: extract_load = w;
    endcase
  endfunction

  // Work is only accepted when not in reset, not flushed and not stalled
  assign live_w = rst_n_i && !flush_i && !stall_i;

  assign misaligned_w = (((operation_i == OP_LDH) || (operation_i == OP_LDHU)) && load_address_i[0])
                     || ((operation_i == OP_LDW) && (load_address_i[1:0] != 2'd0));
  assign private_w    = (load_address_i >= `PRIVATE_REGION_START)
                     && (load_address_i <= `PRIVATE_REGION_END);
  assign illegal_w    = private_w && !privilege_i;
  assign exception_w  = misaligned_w || illegal_w;

  assign accept_w  = (state_q == S_IDLE) && valid_operation_i && live_w;
  assign mem_ret_w = (state_q == S_WAIT_MEMORY) && bus.load_valid_i && !drop_q && live_w;

`ifdef LSU_STORE_FORWARD_EN
  // Forwarding build: a store-buffer hit short-cuts the memory read
  assign fwd_hit_w   = accept_w && !exception_w && bus.foward_match_i;
  assign mem_go_w    = accept_w && !exception_w && !bus.foward_match_i;
  assign hold_w      = 1'b0;
  assign fwd_addr_w  = accept_w ? load_address_i[31:2] : 30'd0;
  assign result_d    = fwd_hit_w ? extract_load(operation_i, load_address_i[1:0], bus.foward_data_i)
                                 : extract_load(op_q, addr_lo_q, bus.load_data_i);
  logic unused_w;
  assign unused_w = bus.buffer_empty_i;
`else
  // Ordered build: the read waits until every buffered store has drained
  assign fwd_hit_w   = 1'b0;
  assign mem_go_w    = accept_w && !exception_w && bus.buffer_empty_i;
  assign hold_w      = accept_w && !exception_w && !bus.buffer_empty_i;
  assign fwd_addr_w  = 30'd0;
  assign result_d    = extract_load(op_q, addr_lo_q, bus.load_data_i);
  logic unused_w;
  assign unused_w = ^{bus.foward_match_i, bus.foward_data_i};
`endif

  assign result_en_w = fwd_hit_w || mem_ret_w;
  assign req_w       = mem_go_w;
  assign req_addr_w  = mem_go_w ? {load_address_i[31:2], 2'b00} : 32'd0;

  assign bus.load_request_o   = req_w;
  assign bus.load_address_o   = req_addr_w;
  assign bus.foward_address_o = fwd_addr_w;

  // State register and stale-response drop flag
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Operation context and result capture; gated by accept/return, no reset
  always_ff @(posedge clk_i) begin
    if (accept_w) begin
      op_q      <= operation_i;
      addr_lo_q <= load_address_i[1:0];
    end
    if (result_en_w) begin
      result_q <= result_d;
    end
  end

  // Next state; flush wins over stall, a flushed read's beat is discarded
  always_comb begin
    state_d = state_q;
    // The drop flag tracks the bus even under stall so no beat is miscounted
    drop_d  = drop_q && !bus.load_valid_i;
    if (flush_i && (state_q == S_WAIT_MEMORY) && !(bus.load_valid_i && !drop_q)) begin
      drop_d = 1'b1;
    end
    if (flush_i) begin
      state_d = S_IDLE;
    end else if (!stall_i) begin
      case (state_q)
        S_IDLE: begin
          if (fwd_hit_w) begin
            state_d = S_WAIT_ACCEPT;
          end else if (mem_go_w) begin
            state_d = S_WAIT_MEMORY;
          end
        end
        S_WAIT_MEMORY: begin
          if (mem_ret_w) begin
            state_d = S_WAIT_ACCEPT;
          end
        end
        S_WAIT_ACCEPT: begin
          if (!wait_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs; exceptions complete in the accepting cycle with zero data
  always_comb begin
    idle_o           = 1'b0;
    data_valid_o     = 1'b0;
    loaded_data_o    = 32'd0;
    misaligned_o     = 1'b0;
    illegal_access_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        idle_o = !hold_w;
        if (accept_w && exception_w) begin
          data_valid_o     = 1'b1;
          misaligned_o     = misaligned_w;
          illegal_access_o = illegal_w;
        end
      end
      S_WAIT_MEMORY: begin
        idle_o = 1'b0;
      end
      S_WAIT_ACCEPT: begin
        data_valid_o  = 1'b1;
        loaded_data_o = result_q;
        idle_o        = !wait_i && !stall_i;
      end
      default: begin
        idle_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed cases plus randomized loads
// compared against an arithmetic reference model.
`ifndef PRIVATE_REGION_START
`define PRIVATE_REGION_START 32'hF000_0000
`endif
`ifndef PRIVATE_REGION_END
`define PRIVATE_REGION_END 32'hF00F_FFFF
`endif

module tb_load_unit;
  localparam logic [2:0] LDB  = 3'd0;
  localparam logic [2:0] LDBU = 3'd1;
  localparam logic [2:0] LDH  = 3'd2;
  localparam logic [2:0] LDHU = 3'd3;
  localparam logic [2:0] LDW  = 3'd4;
  localparam logic [31:0] PRIV_LO = `PRIVATE_REGION_START;
  localparam logic [31:0] PRIV_HI = `PRIVATE_REGION_END;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, privilege, valid_op, wait_hold;
  logic [31:0] address;
  logic [2:0]  op;
  logic [31:0] loaded;
  logic        dv, idle, ill, mis;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  load_unit_if bus();

  load_unit dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .stall_i           (stall),
    .flush_i           (flush),
    .privilege_i       (privilege),
    .valid_operation_i (valid_op),
    .load_address_i    (address),
    .operation_i       (op),
    .wait_i            (wait_hold),
    .bus               (bus),
    .loaded_data_o     (loaded),
    .data_valid_o      (dv),
    .idle_o            (idle),
    .illegal_access_o  (ill),
    .misaligned_o      (mis)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: value from plain lane arithmetic, exceptions from size/region
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic priv,
                                input logic [31:0] w, output logic [31:0] v,
                                output logic m, output logic il);
    logic [31:0] size, lane, b, h;
    size = (o == LDW) ? 32'd4 : (((o == LDH) || (o == LDHU)) ? 32'd2 : 32'd1);
    m    = (a % size) != 32'd0;
    il   = !priv && (a >= PRIV_LO) && (a <= PRIV_HI);
    lane = a % 32'd4;
    b    = (w >> (32'd8 * lane)) & 32'hFF;
    h    = (w >> (32'd16 * (lane / 32'd2))) & 32'hFFFF;
    case (o)
      LDB:     v = (b >= 32'h80)   ? b + 32'hFFFF_FF00 : b;
      LDBU:    v = b;
      LDH:     v = (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      LDHU:    v = h;
      default: v = w;
    endcase
  endfunction

  // One load, started and finished just after a rising edge
  task automatic run_load(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic priv, input logic [31:0] w, input bit fwd,
                          input int lat, input int empty_wait, input int hold);
    logic [31:0] ev;
    logic        em, ei;
    bit          use_fwd;
    model(o, a, priv, w, ev, em, ei);
`ifdef LSU_STORE_FORWARD_EN
    use_fwd = fwd;
`else
    use_fwd = 1'b0;
`endif
    op = o; address = a; privilege = priv; valid_op = 1'b1;
    wait_hold = (hold > 0);
    bus.foward_match_i = fwd;
    bus.foward_data_i  = w;
    bus.buffer_empty_i = (empty_wait == 0);
    if (em || ei) begin
      @(negedge clk);
      check({tag, ".exc_dv"}, dv, 1);
      check({tag, ".mis"}, mis, em);
      check({tag, ".ill"}, ill, ei);
      check({tag, ".exc_data"}, loaded, 0);
      check({tag, ".exc_req"}, bus.load_request_o, 0);
      @(posedge clk); #1;
      valid_op = 1'b0; bus.foward_match_i = 1'b0; bus.buffer_empty_i = 1'b1;
      @(negedge clk);
      check({tag, ".exc_after_dv"}, dv, 0);
      check({tag, ".exc_after_idle"}, idle, 1);
      @(posedge clk); #1;
      return;
    end
`ifndef LSU_STORE_FORWARD_EN
    for (int k = 0; k < empty_wait; k++) begin
      @(negedge clk);
      check({tag, ".drain_idle"}, idle, 0);
      check({tag, ".drain_req"}, bus.load_request_o, 0);
      @(posedge clk); #1;
    end
    bus.buffer_empty_i = 1'b1;
`endif
    @(negedge clk);
`ifdef LSU_STORE_FORWARD_EN
    check({tag, ".fwd_addr"}, {2'b00, bus.foward_address_o}, {2'b00, a[31:2]});
`else
    check({tag, ".fwd_addr"}, {2'b00, bus.foward_address_o}, 0);
`endif
    check({tag, ".acc_dv"}, dv, 0);
    if (use_fwd) begin
      check({tag, ".fwd_req"}, bus.load_request_o, 0);
      @(posedge clk); #1;
      valid_op = 1'b0; bus.foward_match_i = 1'b0;
    end else begin
      check({tag, ".req"}, bus.load_request_o, 1);
      check({tag, ".req_addr"}, bus.load_address_o, a & 32'hFFFF_FFFC);
      @(posedge clk); #1;
      valid_op = 1'b0; bus.foward_match_i = 1'b0;
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        check({tag, ".wm_req"}, bus.load_request_o, 0);
        check({tag, ".wm_dv"}, dv, 0);
        check({tag, ".wm_idle"}, idle, 0);
        @(posedge clk); #1;
      end
      bus.load_valid_i = 1'b1; bus.load_data_i = w;
      @(negedge clk);
      check({tag, ".beat_dv"}, dv, 0);
      @(posedge clk); #1;
      bus.load_valid_i = 1'b0; bus.load_data_i = $urandom;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, ".hold_dv"}, dv, 1);
      check({tag, ".hold_data"}, loaded, ev);
      check({tag, ".hold_idle"}, idle, 0);
      @(posedge clk); #1;
    end
    wait_hold = 1'b0;
    @(negedge clk);
    check({tag, ".dv"}, dv, 1);
    check({tag, ".data"}, loaded, ev);
    check({tag, ".acc_idle"}, idle, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, ".done_dv"}, dv, 0);
    check({tag, ".done_idle"}, idle, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  ro;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; privilege = 1'b0; wait_hold = 1'b0;
    valid_op = 1'b1; address = 32'h100; op = LDW;
    bus.load_valid_i = 1'b0; bus.load_data_i = 32'd0; bus.buffer_empty_i = 1'b1;
    bus.foward_data_i = 32'd0; bus.foward_match_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", bus.load_request_o, 0);
    check("rst_idle", idle, 1);
    check("rst_dv", dv, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; valid_op = 1'b0;
    @(negedge clk);
    check("rst_idle2", idle, 1);
    check("rst_data", loaded, 0);
    check("rst_mis", mis, 0);
    check("rst_ill", ill, 0);
    check("rst_addr", bus.load_address_o, 0);
    @(posedge clk); #1;

    run_load("ldw", LDW, 32'h100, 1'b0, 32'hDEAD_BEEF, 1'b0, 2, 0, 0);
    run_load("ldb", LDB, 32'h103, 1'b0, 32'h80FF_FF00, 1'b0, 1, 0, 0);
    run_load("ldbu", LDBU, 32'h103, 1'b0, 32'h80FF_FF00, 1'b0, 0, 0, 0);
    run_load("ldh_mis", LDH, 32'h101, 1'b1, 32'h1111_2222, 1'b0, 0, 0, 0);
    run_load("priv0", LDW, PRIV_LO, 1'b0, 32'hCAFE_F00D, 1'b0, 0, 0, 0);
    run_load("priv1", LDW, PRIV_LO, 1'b1, 32'hCAFE_F00D, 1'b0, 1, 0, 0);
    run_load("fwd", LDHU, 32'h202, 1'b0, 32'h1234_5678, 1'b1, 1, 3, 0);
    run_load("hold", LDH, 32'h402, 1'b0, 32'h8001_7FFF, 1'b0, 1, 0, 4);

    // Stall in IDLE must not issue a read
    stall = 1'b1; valid_op = 1'b1; op = LDW; address = 32'h500; bus.buffer_empty_i = 1'b1;
    @(negedge clk);
    check("stall_req", bus.load_request_o, 0);
    @(posedge clk); #1;
    stall = 1'b0;
    run_load("post_stall", LDW, 32'h500, 1'b0, 32'h0BAD_CAFE, 1'b0, 0, 0, 0);

    // Flush while waiting on memory; the late beat must be ignored
    op = LDW; address = 32'h300; privilege = 1'b0; valid_op = 1'b1;
    bus.buffer_empty_i = 1'b1; bus.foward_match_i = 1'b0;
    @(negedge clk);
    check("fl_req", bus.load_request_o, 1);
    @(posedge clk); #1;
    valid_op = 1'b0;
    @(negedge clk);
    check("fl_wm_idle", idle, 0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fl_idle", idle, 1);
    check("fl_dv", dv, 0);
    @(posedge clk); #1;
    bus.load_valid_i = 1'b1; bus.load_data_i = 32'h5555_AAAA;
    @(negedge clk);
    check("fl_late_dv", dv, 0);
    @(posedge clk); #1;
    bus.load_valid_i = 1'b0;
    @(negedge clk);
    check("fl_late_dv2", dv, 0);
    check("fl_late_idle", idle, 1);
    @(posedge clk); #1;
    run_load("post_flush", LDW, 32'h304, 1'b0, 32'h600D_D00D, 1'b0, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 4));
      ra = ($urandom_range(0, 3) == 0) ? PRIV_LO + 32'($urandom_range(0, 4095)) : $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      run_load("rnd", ro, ra, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
